// File: rtl/writeback_stage_pkg.sv
// Shared encodings, register constants and the queue entry format for the writeback stage.
// The entry is resolved at acceptance so the queue never carries raw control fields.
package writeback_stage_pkg;

  typedef enum logic [1:0] {
    DST_RT  = 2'b00,
    DST_RD  = 2'b01,
    DST_RA  = 2'b10,
    DST_RSV = 2'b11
  } regdst_t;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_MEM  = 2'b01,
    SRC_LINK = 2'b10,
    SRC_RSV  = 2'b11
  } memtoreg_t;

  localparam logic [4:0]  REG_ZERO    = 5'd0;
  localparam logic [4:0]  REG_RA      = 5'd31;
  localparam logic [31:0] LINK_OFFSET = 32'd8;
  localparam int          ENTRY_W     = 38;

  typedef struct packed {
    logic        write;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_entry_t;

  // Reserved selector codes resolve to harmless values; their write flag is forced low anyway.
  function automatic wb_entry_t resolve_entry(
    input logic        regwrite,
    input logic [1:0]  regdst,
    input logic [1:0]  memtoreg,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [31:0] alu,
    input logic [31:0] mem,
    input logic [31:0] pc
  );
    wb_entry_t e;
    logic [4:0]  a;
    logic [31:0] d;
    case (regdst_t'(regdst))
      DST_RT:  a = rt;
      DST_RD:  a = rd;
      DST_RA:  a = REG_RA;
      default: a = REG_ZERO;
    endcase
    case (memtoreg_t'(memtoreg))
      SRC_ALU:  d = alu;
      SRC_MEM:  d = mem;
      SRC_LINK: d = pc + LINK_OFFSET;
      default:  d = alu;
    endcase
    e.addr  = a;
    e.data  = d;
    e.write = regwrite && (regdst != DST_RSV) && (memtoreg != SRC_RSV) && (a != REG_ZERO);
    return e;
  endfunction

endpackage

// File: rtl/writeback_stage_wb_fifo.sv
// Circular queue of resolved writeback entries with wrapping pointers and an occupancy count.
// Push and pop are each ignored when the queue cannot honour them.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 38
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(1'b0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == CNT_ZERO);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign rdata     = mem_r[rd_ptr_r];

  // Pointers and occupancy; DEPTH is a power of two so pointer overflow is the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: resolves destination/data on acceptance, queues the result, and
// issues one registered register-file write per popped entry while counting retired writes.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNTW  = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_regwrite,
  input  logic [1:0]      in_regdst,
  input  logic [1:0]      in_memtoreg,
  input  logic [4:0]      in_rt,
  input  logic [4:0]      in_rd,
  input  logic [31:0]     in_alu,
  input  logic [31:0]     in_mem,
  input  logic [31:0]     in_pc,
  input  logic            wb_hold,
  output logic [4:0]      WriteRegister,
  output logic [31:0]     WriteData,
  output logic            RegWrite,
  output logic [CNTW-1:0] retired
);

  localparam logic [CNTW-1:0] RET_ONE  = CNTW'(1'b1);
  localparam logic [CNTW-1:0] RET_ZERO = CNTW'(1'b0);

  wb_entry_t entry_s;
  wb_entry_t head_s;
  logic      full_s;
  logic      empty_s;
  logic      accept_s;
  logic      pop_s;

  assign entry_s  = resolve_entry(in_regwrite, in_regdst, in_memtoreg,
                                  in_rt, in_rd, in_alu, in_mem, in_pc);
  assign in_ready = !full_s;
  assign accept_s = in_valid && !full_s;
  assign pop_s    = !wb_hold && !empty_s;

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (Clk),
    .rst   (Reset),
    .push  (accept_s),
    .pop   (pop_s),
    .wdata (entry_s),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Register-file write port: loaded on pop, write enable drops on any non-pop edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      WriteRegister <= 5'd0;
      WriteData     <= 32'd0;
      RegWrite      <= 1'b0;
      retired       <= RET_ZERO;
    end else if (pop_s) begin
      WriteRegister <= head_s.addr;
      WriteData     <= head_s.data;
      RegWrite      <= head_s.write;
      retired       <= head_s.write ? (retired + RET_ONE) : retired;
    end else begin
      RegWrite      <= 1'b0;
    end
  end

endmodule
